pim_result_serializer: RTL
==========================

# pim_result_serializer

Transmit-side counterpart of the PIM activation buffer. It captures one wide 288-bit PIM result vector in a single cycle and streams it out as nine 32-bit words over a valid/ready handshake to the bus-side readback logic. Word order matches the activation packing: word 0 is bits [287:256], word 8 is bits [31:0]. It sits between the PIM macro output and the peripheral register/DMA interface in `pim_wrap`.

## Interface
- NUM_WORDS, 9, words per result vector
- WORD_W, 32, width of one streamed word
- i_clk  in  1  single clock, all logic on posedge
- i_rst  in  1  synchronous, active-high reset
- i_result_valid  in  1  capture strobe for i_result
- i_result  in  NUM_WORDS*WORD_W  wide PIM result vector
- i_clear  in  1  synchronous abort; drops the current vector and clears o_overrun
- o_idle  out  1  serializer can accept a vector this cycle
- o_data  out  WORD_W  current word
- o_valid  out  1  o_data is valid
- i_ready  in  1  consumer accepts o_data
- o_counter  out  8  index of the word currently on o_data (0..NUM_WORDS-1)
- o_last  out  1  o_valid and o_counter==NUM_WORDS-1
- o_overrun  out  1  sticky: a strobe arrived while the vector could not be accepted

## Operation
- States: IDLE, SEND.
- IDLE: on i_result_valid, latch i_result into a shadow register, set counter=0, go to SEND.
- SEND:
  - o_valid=1 and o_data = shadow word[counter]; MSB word first.
  - A handshake is o_valid&i_ready. It increments counter.
  - A handshake on counter==NUM_WORDS-1 returns the block to IDLE.
  - Without i_ready, o_data and o_counter hold stable.
- o_idle = (state==IDLE) | (SEND & o_last & i_ready). This is combinational from i_ready, so a back-to-back vector is accepted on the final handshake cycle. It then restarts SEND at counter=0 with the new data and no bubble.
- i_result_valid while o_idle==0: the vector is dropped, o_overrun is set, and the in-flight stream is unaffected.
- i_clear (priority below i_rst, above everything else): state→IDLE, counter→0, o_overrun→0. Any i_result_valid in the same cycle is ignored.
- When o_valid==0, o_data is driven 0 and o_counter is 0.

## Timing
- Reset values:
  - o_valid=0, o_data=0, o_counter=0, o_last=0, o_overrun=0.
  - o_idle=1 (state IDLE); shadow register cleared.
- Latency: strobe at edge N → o_valid=1 with word 0 after edge N (visible in cycle N+1).
- Throughput: with i_ready held high, 9 words in 9 consecutive cycles. Back-to-back vectors stream with 0 gap cycles.
- Reset mid-stream: the next cycle is the reset state and the partial vector is lost. The same applies to i_clear.
- A strobe and handshake on a non-last word in the same cycle: the handshake proceeds and o_overrun is set.
- The counter never exceeds NUM_WORDS-1; no wrap occurs except via the return to IDLE.

## Structure
- Shared package `pim_pkg`:
  - PIM_WORD_W=32 and PIM_ACT_WORDS=9, used by both the activation buffer and this block.
  - Serializer state enum {IDLE, SEND}.
- No sub-module. The word select is an indexed part-select of the shadow register, counted from the MSB end.
- Expected size: ~150 lines of RTL.

## Test plan
- Reset then idle: after reset release, o_idle=1, o_valid=0, o_data=0, o_overrun=0 for 5 cycles.
- Single vector, i_ready=1:
  - Stimulus: i_result = {32'h0000_0000, 32'h1111_1111, …, 32'h8888_8888}.
  - Response: o_data is 0x00000000..0x88888888 on 9 consecutive cycles, o_counter 0..8, and o_last only on 0x88888888.
- Backpressure: i_ready toggles 1,0,0,1,… → each word is held stable while i_ready=0; exactly 9 handshakes occur; no word is duplicated or skipped.
- Back-to-back: a second strobe (all words 0xA5A5A5A5) is asserted on the last-handshake cycle of vector 1 → the first A5 word appears the next cycle with o_counter=0, and o_overrun stays 0.
- Overrun and clear:
  - A strobe at counter=3 → o_overrun=1 and the stream continues with the original words 3..8.
  - Then i_clear → o_overrun=0 and o_idle=1.
- Reset/clear mid-stream: i_rst (or i_clear) at counter=5 → the next cycle has o_valid=0 and o_counter=0. A new strobe then restarts from word 0.

Source files
------------

// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared PIM word geometry and serializer state encoding
package pim_pkg;

    localparam int PIM_WORD_W    = 32;
    localparam int PIM_ACT_WORDS = 9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/pim_result_serializer.sv
// rtl/pim_result_serializer.sv - captures one wide PIM result and streams it MSB word first
module pim_result_serializer
    import pim_pkg::*;
#(
    parameter int NUM_WORDS = PIM_ACT_WORDS,
    parameter int WORD_W    = PIM_WORD_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_result_valid,
    input  logic [NUM_WORDS*WORD_W-1:0] i_result,
    input  logic                        i_clear,
    output logic                        o_idle,
    output logic [WORD_W-1:0]           o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [7:0]                  o_counter,
    output logic                        o_last,
    output logic                        o_overrun
);

    localparam int         VEC_W    = NUM_WORDS * WORD_W;
    localparam int         SEL_W    = $clog2(VEC_W);
    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    ser_state_t         r_state;
    logic [7:0]         r_counter;
    logic [VEC_W-1:0]   r_shadow;
    logic               r_overrun;

    logic               w_send;
    logic               w_last;
    logic               w_handshake;
    logic               w_idle;
    logic               w_accept;
    logic               w_drop;
    logic [7:0]         w_word_idx;
    logic [SEL_W-1:0]   w_bit_base;

    assign w_send      = (r_state == SEND);
    assign w_last      = w_send && (r_counter == LAST_IDX);
    assign w_handshake = w_send && i_ready;
    // Idle also on the final handshake so a new vector follows without a bubble.
    assign w_idle      = !w_send || (w_last && i_ready);
    assign w_accept    = i_result_valid && w_idle;
    assign w_drop      = i_result_valid && !w_idle;

    // Word 0 lives in the top bits of the shadow register.
    assign w_word_idx  = LAST_IDX - r_counter;
    assign w_bit_base  = SEL_W'(w_word_idx) * SEL_W'(WORD_W);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_shadow  <= '0;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow  <= i_result;
                r_counter <= '0;
                r_state   <= SEND;
            end else if (w_handshake) begin
                if (w_last) begin
                    r_state   <= IDLE;
                    r_counter <= '0;
                end else begin
                    r_counter <= r_counter + 8'd1;
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_idle    = w_idle;
    assign o_valid   = w_send;
    assign o_data    = w_send ? r_shadow[w_bit_base +: WORD_W] : '0;
    assign o_counter = w_send ? r_counter : '0;
    assign o_last    = w_last;
    assign o_overrun = r_overrun;

endmodule
